wbc_irq_sched: RTL and testbench

WBC_IRQ_SCHED -- requirements
Module: wbc_irq_sched

---
 rtl/wbc_irq_pkg.sv | 25 ++
 rtl/wbc_irq_pick.sv | 60 ++++++
 rtl/wbc_irq_sched.sv | 190 +++++++++++++++++++
 tb/tb_wbc_irq_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbc_irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wbc_irq_pkg
//  Description : Shared definitions for the interrupt scheduler: scheduler
//                state encoding, priority-level width and timeout counter
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package wbc_irq_pkg;

    // Width of one priority level (cpu_pri and each LVL field)
    localparam int c_lvl_w = 3;

    // Width of the grant timeout counter and of the TMO parameter
    localparam int c_tmo_w = 8;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : wbc_irq_pkg
`default_nettype wire

// File: rtl/wbc_irq_pick.sv
`default_nettype none
// ============================================================================
//  Module      : wbc_irq_pick
//  Description : Combinational winner selection. A source is eligible when
//                it is pending and its level is strictly above the CPU
//                priority. The highest eligible level wins; among equal
//                levels the first one found scanning upward from the
//                round-robin pointer (wrapping N-1 -> 0) wins.
//  Ports       : i_pend    - pending latch state, one bit per source
//                i_cpu_pri - current CPU priority level
//                i_rr_ptr  - round-robin start index
//                o_idx     - winning source index (0 when none)
//                o_vld     - at least one source is eligible
//  Revision    : 1.0 - initial release
// ============================================================================
module wbc_irq_pick
    import wbc_irq_pkg::*;
#(
    parameter int                   N   = 4,
    parameter logic [N*c_lvl_w-1:0] LVL = {N{3'o4}}
) (
    input  logic [N-1:0]                             i_pend,
    input  logic [c_lvl_w-1:0]                       i_cpu_pri,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]     i_rr_ptr,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]     o_idx,
    output logic                                     o_vld
);

    localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;

    int                 w_sum;
    logic [c_lvl_w-1:0] w_cur_lvl;
    logic [c_lvl_w-1:0] w_best_lvl;

    always_comb begin
        o_vld      = 1'b0;
        o_idx      = '0;
        w_best_lvl = '0;
        w_sum      = 0;
        w_cur_lvl  = '0;
        for (int j = 0; j < N; j++) begin
            // rr_ptr < N and j < N, so one conditional subtract is a full modulo
            w_sum = int'(i_rr_ptr) + j;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_cur_lvl = LVL[w_sum*c_lvl_w +: c_lvl_w];
            // Strict '>' on the best level keeps the earliest hit in scan
            // order, which is exactly the round-robin tie break.
            if (i_pend[w_sum] && (w_cur_lvl > i_cpu_pri) &&
                (!o_vld || (w_cur_lvl > w_best_lvl))) begin
                o_vld      = 1'b1;
                o_idx      = c_idx_w'(w_sum);
                w_best_lvl = w_cur_lvl;
            end
        end
    end

endmodule : wbc_irq_pick
`default_nettype wire

// File: rtl/wbc_irq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : wbc_irq_sched
//  Description : Interrupt scheduler in front of a vectored interrupt
//                controller. Rising edges on src_req latch pending bits;
//                the highest-level eligible source is presented one-hot on
//                vic_ireq, and after the controller acknowledges it the
//                source receives a one-clock src_ack pulse.
//  Ports       : wb_clk_i  - system clock
//                wb_rst_i  - asynchronous active-high reset
//                src_req   - source request lines (rising-edge triggered)
//                cpu_pri   - current CPU priority level
//                vic_stb   - controller vector strobe (freezes the grant)
//                vic_iack  - acknowledgement pulses from the controller
//                vic_ireq  - one-hot request to the controller
//                src_ack   - one-clock service pulse per source
//                pend_o    - pending latch state
//                tmo_o     - sticky grant-timeout flag
//  Options     : WBC_IRQ_SCHED_TMO_EN - when defined, a grant that is not
//                acknowledged within TMO clocks is abandoned, its pending bit
//                cleared and tmo_o set. When undefined, a grant waits
//                indefinitely and tmo_o is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module wbc_irq_sched
    import wbc_irq_pkg::*;
#(
    parameter int                   N   = 4,
    parameter logic [N*c_lvl_w-1:0] LVL = {N{3'o4}},
    parameter logic [c_tmo_w-1:0]   TMO = 8'd255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [N-1:0]       src_req,
    input  logic [c_lvl_w-1:0] cpu_pri,
    input  logic               vic_stb,
    input  logic [N-1:0]       vic_iack,
    output logic [N-1:0]       vic_ireq,
    output logic [N-1:0]       src_ack,
    output logic [N-1:0]       pend_o,
    output logic               tmo_o
);

    localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;

    state_t             r_state;
    logic [N-1:0]       r_req_d;
    logic [N-1:0]       r_pend;
    logic [N-1:0]       r_vic_ireq;
    logic [N-1:0]       r_src_ack;
    logic [c_idx_w-1:0] r_winner;
    logic [c_idx_w-1:0] r_rr_ptr;

    logic [N-1:0]       w_rise;
    logic [N-1:0]       w_win_mask;
    logic [N-1:0]       w_tmo_clr;
    logic [c_idx_w-1:0] w_pick_idx;
    logic [c_idx_w-1:0] w_next_ptr;
    logic               w_pick_vld;
    logic               w_win_elig;
    logic               w_higher;
    logic               w_win_iack;
    logic               w_tmo_hit;
    logic [c_lvl_w-1:0] w_lvl [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lvl
            assign w_lvl[gi] = LVL[gi*c_lvl_w +: c_lvl_w];
        end
    endgenerate

    wbc_irq_pick #(
        .N   (N),
        .LVL (LVL)
    ) u_pick (
        .i_pend    (r_pend),
        .i_cpu_pri (cpu_pri),
        .i_rr_ptr  (r_rr_ptr),
        .o_idx     (w_pick_idx),
        .o_vld     (w_pick_vld)
    );

    assign w_rise     = src_req & ~r_req_d;
    assign w_win_mask = {{(N-1){1'b0}}, 1'b1} << r_winner;
    assign w_win_iack = vic_iack[r_winner];
    assign w_win_elig = r_pend[r_winner] && (w_lvl[r_winner] > cpu_pri);
    // Any eligible source at a strictly higher level than the current winner
    assign w_higher   = w_pick_vld && (w_lvl[w_pick_idx] > w_lvl[r_winner]);
    assign w_next_ptr = (r_winner == c_idx_w'(N-1)) ? '0 : r_winner + 1'b1;
    assign w_tmo_clr  = w_tmo_hit ? w_win_mask : '0;

`ifdef WBC_IRQ_SCHED_TMO_EN
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_tmo;

    // Counter holds the number of GRANT clocks already spent; the TMO-th
    // GRANT clock without an acknowledge abandons the grant.
    assign w_tmo_hit = (r_state == ST_GRANT) && !w_win_iack &&
                       (r_tmo_cnt == TMO - 1'b1);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else begin
            if (r_state == ST_GRANT) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_tmo_hit) begin
                r_tmo <= 1'b1;
            end
        end
    end

    assign tmo_o = r_tmo;
`else
    assign w_tmo_hit = 1'b0;
    assign tmo_o     = 1'b0;
`endif

    // Edge history and pending latches. A fresh rising edge overrides a
    // same-clock clear from an acknowledge or a timeout.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_req_d <= '0;
            r_pend  <= '0;
        end else begin
            r_req_d <= src_req;
            r_pend  <= (r_pend & ~vic_iack & ~w_tmo_clr) | w_rise;
        end
    end

    // Scheduler FSM with registered request and acknowledge outputs.
    // vic_ireq rises on the first clock spent in GRANT, two clocks after
    // the pending bit that caused the grant.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_winner   <= '0;
            r_rr_ptr   <= '0;
            r_vic_ireq <= '0;
            r_src_ack  <= '0;
        end else begin
            r_src_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_vic_ireq <= '0;
                    if (w_pick_vld) begin
                        r_winner <= w_pick_idx;
                        r_state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_win_iack) begin
                        r_vic_ireq <= '0;
                        r_src_ack  <= w_win_mask;
                        r_state    <= ST_DONE;
                    end else if (w_tmo_hit) begin
                        r_vic_ireq <= '0;
                        r_rr_ptr   <= w_next_ptr;
                        r_state    <= ST_IDLE;
                    end else if (!vic_stb && (!w_win_elig || w_higher)) begin
                        // Withdraw; pend is untouched so IDLE re-arbitrates
                        r_vic_ireq <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_vic_ireq <= w_win_mask;
                    end
                end
                ST_DONE: begin
                    r_vic_ireq <= '0;
                    r_rr_ptr   <= w_next_ptr;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_vic_ireq <= '0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign vic_ireq = r_vic_ireq;
    assign src_ack  = r_src_ack;
    assign pend_o   = r_pend;

endmodule : wbc_irq_sched
`default_nettype wire

// File: tb/tb_wbc_irq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wbc_irq_sched
//  Description : Self-checking bench for wbc_irq_sched. A behavioural model
//                tracks pending bits, the current grant and the round-robin
//                pointer; directed scenarios and random traffic are compared
//                against it every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wbc_irq_sched;

    localparam int           N       = 4;
    localparam int           TMO_CFG = 10;
    // src3..src0 levels = 4, 6, 4, 4 : three tied sources plus one above them
    localparam logic [3*N-1:0] LVL_CFG = {3'd4, 3'd6, 3'd4, 3'd4};
    int m_lvl [N] = '{4, 4, 6, 4};

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b1;
    logic [N-1:0] src_req  = '0;
    logic [2:0]   cpu_pri  = '0;
    logic         vic_stb  = 1'b1;
    logic [N-1:0] vic_iack = '0;
    logic [N-1:0] vic_ireq;
    logic [N-1:0] src_ack;
    logic [N-1:0] pend_o;
    logic         tmo_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: phase 0 = waiting, 1 = granting m_w, 2 = acknowledging
    logic [N-1:0] m_pend, m_prev, m_ireq, m_ack;
    logic         m_tmo;
    int           m_phase, m_w, m_age, m_rr;

    wbc_irq_sched #(
        .N   (N),
        .LVL (LVL_CFG),
        .TMO (8'(TMO_CFG))
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .src_req  (src_req),
        .cpu_pri  (cpu_pri),
        .vic_stb  (vic_stb),
        .vic_iack (vic_iack),
        .vic_ireq (vic_ireq),
        .src_ack  (src_ack),
        .pend_o   (pend_o),
        .tmo_o    (tmo_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Highest level among eligible sources, or -1 when none
    function automatic int elig_max(input logic [N-1:0] p, input logic [2:0] pri);
        int best = -1;
        for (int i = 0; i < N; i++)
            if (p[i] && m_lvl[i] > int'(pri) && m_lvl[i] > best) best = m_lvl[i];
        return best;
    endfunction

    // First source at the top eligible level, counting upward from m_rr
    function automatic int model_pick(input logic [N-1:0] p, input logic [2:0] pri);
        int lv = elig_max(p, pri);
        if (lv < 0) return -1;
        for (int j = 0; j < N; j++) begin
            int idx = (m_rr + j) % N;
            if (p[idx] && m_lvl[idx] == lv) return idx;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_pend = '0; m_prev = '0; m_ireq = '0; m_ack = '0; m_tmo = 1'b0;
        m_phase = 0; m_w = 0; m_age = 0; m_rr = 0;
    endtask

    // Advance the model across one clock edge using the current inputs
    task automatic model_step();
        logic [N-1:0] rise, clr;
        int  pk;
        bit  tmo_hit;
        rise    = src_req & ~m_prev;
        clr     = vic_iack;
        m_ack   = '0;
        tmo_hit = 1'b0;
`ifdef WBC_IRQ_SCHED_TMO_EN
        tmo_hit = (m_age == TMO_CFG - 1);
`endif
        if (m_phase == 0) begin
            m_ireq = '0;
            pk = model_pick(m_pend, cpu_pri);
            if (pk >= 0) begin
                m_w = pk; m_phase = 1; m_age = 0;
            end
        end else if (m_phase == 1) begin
            if (vic_iack[m_w]) begin
                m_phase = 2; m_ireq = '0; m_ack = N'(1) << m_w;
            end else if (tmo_hit) begin
                clr[m_w] = 1'b1; m_tmo = 1'b1; m_rr = (m_w + 1) % N;
                m_phase = 0; m_ireq = '0;
            end else if (!vic_stb &&
                         (!(m_pend[m_w] && m_lvl[m_w] > int'(cpu_pri)) ||
                          elig_max(m_pend, cpu_pri) > m_lvl[m_w])) begin
                m_phase = 0; m_ireq = '0;
            end else begin
                m_ireq = N'(1) << m_w; m_age++;
            end
        end else begin
            m_rr = (m_w + 1) % N; m_phase = 0; m_ireq = '0;
        end
        m_pend = (m_pend & ~clr) | rise;
        m_prev = src_req;
    endtask

    task automatic step(input logic [N-1:0] req, input logic [2:0] pri,
                        input logic stb, input logic [N-1:0] iack);
        @(negedge wb_clk_i);
        src_req = req; cpu_pri = pri; vic_stb = stb; vic_iack = iack;
        @(posedge wb_clk_i);
        model_step();
        #1;
        chk("vic_ireq", 32'(vic_ireq), 32'(m_ireq));
        chk("src_ack",  32'(src_ack),  32'(m_ack));
        chk("pend_o",   32'(pend_o),   32'(m_pend));
        chk("tmo_o",    32'(tmo_o),    32'(m_tmo));
    endtask

    task automatic do_reset();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1; src_req = '0; vic_iack = '0; vic_stb = 1'b1; cpu_pri = '0;
        #1;
        chk("rst_ireq", 32'(vic_ireq), 32'd0);
        chk("rst_ack",  32'(src_ack),  32'd0);
        chk("rst_pend", 32'(pend_o),   32'd0);
        chk("rst_tmo",  32'(tmo_o),    32'd0);
        m_reset();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    // Step with idle inputs until the DUT shows a request; bounded
    task automatic wait_grant(input logic [2:0] pri, input logic stb, output int idx);
        idx = -1;
        for (int k = 0; k < 20 && idx < 0; k++) begin
            step('0, pri, stb, '0);
            for (int b = 0; b < N; b++) if (vic_ireq[b]) idx = b;
        end
        if (idx < 0) chk("grant_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic serve(input logic [2:0] pri, output int idx);
        wait_grant(pri, 1'b1, idx);
        if (idx >= 0) step('0, pri, 1'b1, N'(1) << idx);
    endtask

    initial begin
        int           g;
        logic [N-1:0] req, ia;
        logic [2:0]   pri;
        logic         stb;

        m_reset();
        do_reset();

        // Single request: latency, acknowledge pulse, pend clear
        step(4'b0010, 3'd0, 1'b1, '0);
        chk("lat_pend", 32'(pend_o), 32'h2);
        step('0, 3'd0, 1'b1, '0);
        chk("lat_ireq_1clk", 32'(vic_ireq), 32'h0);
        step('0, 3'd0, 1'b1, '0);
        chk("lat_ireq_2clk", 32'(vic_ireq), 32'h2);
        step('0, 3'd0, 1'b1, 4'b0010);
        chk("ack_pulse", 32'(src_ack), 32'h2);
        chk("ack_pend", 32'(pend_o), 32'h0);
        step('0, 3'd0, 1'b1, '0);
        chk("ack_one_clk", 32'(src_ack), 32'h0);

        // Round robin among equal levels, then pointer wrap back to 0
        do_reset();
        step(4'b1011, 3'd0, 1'b1, '0);
        serve(3'd0, g); chk("rr_first",  32'(g), 32'd0);
        serve(3'd0, g); chk("rr_second", 32'(g), 32'd1);
        serve(3'd0, g); chk("rr_third",  32'(g), 32'd3);
        step(4'b0011, 3'd0, 1'b1, '0);
        serve(3'd0, g); chk("rr_wrap",   32'(g), 32'd0);
        serve(3'd0, g); chk("rr_wrap2",  32'(g), 32'd1);

        // Only the level-6 source clears cpu_pri=4; the others stay pending
        step(4'b1111, 3'd4, 1'b1, '0);
        serve(3'd4, g); chk("prio_win", 32'(g), 32'd2);
        for (int k = 0; k < 4; k++) step('0, 3'd4, 1'b1, '0);
        chk("prio_pend", 32'(pend_o), 32'hb);
        chk("prio_idle", 32'(vic_ireq), 32'h0);

        // Withdrawal on cpu_pri raise, suppressed while vic_stb=1
        do_reset();
        step(4'b0001, 3'd0, 1'b0, '0);
        wait_grant(3'd0, 1'b0, g);
        step('0, 3'd5, 1'b0, '0);
        chk("withdraw_ireq", 32'(vic_ireq), 32'h0);
        chk("withdraw_pend", 32'(pend_o), 32'h1);
        wait_grant(3'd0, 1'b1, g);
        step('0, 3'd5, 1'b1, '0);
        chk("stb_hold1", 32'(vic_ireq), 32'h1);
        step('0, 3'd5, 1'b1, '0);
        chk("stb_hold2", 32'(vic_ireq), 32'h1);
        step('0, 3'd5, 1'b1, 4'b0001);

        // Higher-level source pre-empts an unstrobed grant
        step(4'b0001, 3'd0, 1'b0, '0);
        wait_grant(3'd0, 1'b0, g);
        step(4'b0100, 3'd0, 1'b0, '0);
        step('0, 3'd0, 1'b0, '0);
        chk("preempt_drop", 32'(vic_ireq), 32'h0);
        wait_grant(3'd0, 1'b0, g);
        chk("preempt_win", 32'(g), 32'd2);

        // Reset in the middle of a grant
        do_reset();
        step(4'b0010, 3'd0, 1'b1, '0);
        wait_grant(3'd0, 1'b1, g);
        do_reset();

        // Unacknowledged grant: abandoned after TMO clocks when enabled
        step(4'b1000, 3'd0, 1'b1, '0);
        for (int k = 0; k < TMO_CFG + 4; k++) step('0, 3'd0, 1'b1, '0);
`ifdef WBC_IRQ_SCHED_TMO_EN
        chk("tmo_flag", 32'(tmo_o), 32'd1);
        chk("tmo_pend", 32'(pend_o), 32'h0);
`else
        chk("tmo_flag", 32'(tmo_o), 32'd0);
        chk("tmo_held", 32'(vic_ireq), 32'h8);
`endif
        step('0, 3'd0, 1'b1, 4'b1000);

        // Random traffic against the model
        req = '0; pri = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = req ^ N'($urandom_range(0, (1 << N) - 1));
            ia = '0;
            if (vic_ireq != '0 && $urandom_range(0, 2) == 0) ia = vic_ireq;
            if ($urandom_range(0, 15) == 0) ia[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 7) == 0) pri = 3'($urandom_range(0, 5));
            stb = 1'($urandom_range(0, 1));
            step(req, pri, stb, ia);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wbc_irq_sched
`default_nettype wire
